// File: rtl/serial_bus_arbiter_pkg.sv
// serial_bus_arb_pkg
//   Shared types for the two-master serial port Wishbone arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY, ABORT)
//   MASTER_0/1  : owner / last-grant identifiers (m0 = CPU data port, m1 = debug/DMA)
package serial_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  localparam logic MASTER_0 = 1'b0;
  localparam logic MASTER_1 = 1'b1;

endpackage

// File: rtl/serial_bus_arbiter_if.sv
// serial_bus_arbiter_if
//   One pipelined Wishbone link.
//   master modport : drives cyc, stb, we, adr, dat_w, sel; receives dat_r, ack, err, rty, stall
//   slave modport  : the mirror image
//   AW/DW/SW       : address, data and byte-select widths
interface serial_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = 4
) ();

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [SW-1:0] sel;
  logic [DW-1:0] dat_r;
  logic          ack;
  logic          err;
  logic          rty;
  logic          stall;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack, err, rty, stall
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack, err, rty, stall
  );

endinterface

// File: rtl/serial_bus_arbiter_rr_pick2.sv
// rr_pick2
//   Combinational two-way round-robin pick.
//   req[1:0] in  : request from master 1 / master 0
//   last     in  : id of the master that held the previous grant
//   grant    out : chosen master id (valid only when valid=1)
//   valid    out : at least one request present
module rr_pick2
  import serial_bus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  // On a tie the master that did not go last wins.
  always_comb begin
    valid = |req;
    grant = MASTER_0;
    if (req == 2'b11) begin
      grant = ~last;
    end else if (req[1]) begin
      grant = MASTER_1;
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter
//   Shares the serial port Wishbone slave between m0 (CPU data port) and m1 (debug/DMA).
//   Round-robin grant held for a whole bus cycle, capped pipeline depth, watchdog abort.
//   clk_bus in : bus clock
//   rst_bus in : synchronous active-high reset
//   m0, m1     : master-side links (arbiter acts as their slave)
//   s          : slave-side link (arbiter acts as its master)
//   MAX_OUT    : max accepted-but-unanswered requests (1..15)
//   TIMEOUT    : silent cycles with requests outstanding before abort (>=2)
module serial_bus_arbiter
  import serial_bus_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SW      = 4,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255
) (
  input logic                  clk_bus,
  input logic                  rst_bus,
  serial_bus_arbiter_if.slave  m0,
  serial_bus_arbiter_if.slave  m1,
  serial_bus_arbiter_if.master s
);

  localparam int            WDW        = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
  localparam logic [WDW-1:0] WDOG_LIMIT = WDW'(TIMEOUT - 1);
  localparam logic [3:0]     MAX_OUT_L  = 4'(MAX_OUT);

  arb_state_t     state, state_nx;
  logic           owner, owner_nx;
  logic           last, last_nx;
  logic [3:0]     outstanding, outstanding_nx;
  logic [WDW-1:0] wdog, wdog_nx;

  logic           pick_id, pick_valid;
  logic           own_cyc, own_stb, own_we;
  logic [AW-1:0]  own_adr;
  logic [DW-1:0]  own_dat;
  logic [SW-1:0]  own_sel;
  logic           slave_stb;
  logic           at_cap, accept, resp, resp_counted;

  rr_pick2 u_pick (
    .req   ({m1.cyc, m0.cyc}),
    .last  (last),
    .grant (pick_id),
    .valid (pick_valid)
  );

  always_comb begin
    if (owner == MASTER_1) begin
      own_cyc = m1.cyc;
      own_stb = m1.stb;
      own_we  = m1.we;
      own_adr = m1.adr;
      own_dat = m1.dat_w;
      own_sel = m1.sel;
    end else begin
      own_cyc = m0.cyc;
      own_stb = m0.stb;
      own_we  = m0.we;
      own_adr = m0.adr;
      own_dat = m0.dat_w;
      own_sel = m0.sel;
    end
  end

  assign at_cap = (outstanding == MAX_OUT_L);
  assign accept = slave_stb & ~s.stall;
  assign resp   = s.ack | s.err | s.rty;
  // A response with nothing outstanding is forwarded but not counted.
  assign resp_counted = resp & (outstanding != 4'd0);

  assign s.stb   = slave_stb;
  assign s.we    = own_we;
  assign s.adr   = own_adr;
  assign s.dat_w = own_dat;
  assign s.sel   = own_sel;

  always_ff @(posedge clk_bus) begin
    if (rst_bus) begin
      state       <= IDLE;
      owner       <= MASTER_0;
      last        <= MASTER_1;
      outstanding <= '0;
      wdog        <= '0;
    end else begin
      state       <= state_nx;
      owner       <= owner_nx;
      last        <= last_nx;
      outstanding <= outstanding_nx;
      wdog        <= wdog_nx;
    end
  end

  // Release by the owner takes priority over a watchdog expiry in the same cycle.
  always_comb begin
    state_nx       = state;
    owner_nx       = owner;
    last_nx        = last;
    outstanding_nx = outstanding;
    wdog_nx        = wdog;
    case (state)
      IDLE: begin
        outstanding_nx = '0;
        wdog_nx        = '0;
        if (pick_valid) begin
          owner_nx = pick_id;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (accept && !resp_counted) begin
          outstanding_nx = outstanding + 4'd1;
        end else if (!accept && resp_counted) begin
          outstanding_nx = outstanding - 4'd1;
        end
        if ((outstanding == 4'd0) || resp) begin
          wdog_nx = '0;
        end else begin
          wdog_nx = wdog + 1'b1;
        end
        if (!own_cyc) begin
          state_nx       = IDLE;
          last_nx        = owner;
          outstanding_nx = '0;
          wdog_nx        = '0;
        end else if (wdog == WDOG_LIMIT) begin
          state_nx = ABORT;
        end
      end
      ABORT: begin
        state_nx       = IDLE;
        last_nx        = owner;
        outstanding_nx = '0;
        wdog_nx        = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Only the owner sees slave responses, and only while BUSY; late responses after release are swallowed.
  always_comb begin
    s.cyc     = 1'b0;
    slave_stb = 1'b0;
    m0.ack    = 1'b0;
    m0.err    = 1'b0;
    m0.rty    = 1'b0;
    m0.stall  = 1'b1;
    m0.dat_r  = '0;
    m1.ack    = 1'b0;
    m1.err    = 1'b0;
    m1.rty    = 1'b0;
    m1.stall  = 1'b1;
    m1.dat_r  = '0;
    case (state)
      BUSY: begin
        s.cyc     = own_cyc;
        slave_stb = own_cyc & own_stb & ~at_cap;
        if (owner == MASTER_1) begin
          m1.ack   = s.ack;
          m1.err   = s.err;
          m1.rty   = s.rty;
          m1.stall = s.stall | at_cap;
          m1.dat_r = s.dat_r;
        end else begin
          m0.ack   = s.ack;
          m0.err   = s.err;
          m0.rty   = s.rty;
          m0.stall = s.stall | at_cap;
          m0.dat_r = s.dat_r;
        end
      end
      ABORT: begin
        if (owner == MASTER_1) begin
          m1.err = 1'b1;
        end else begin
          m0.err = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// tb_serial_bus_arbiter
//   Self-checking bench for serial_bus_arbiter (MAX_OUT=4, TIMEOUT=8): directed
//   cycle vectors for the grant/cap/watchdog/abandon corners, then randomized
//   traffic compared against a cycle-level behavioural model.
module tb_serial_bus_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SW      = 4;
  localparam int MAX_OUT = 4;
  localparam int TIMEOUT = 8;

  logic clk_bus = 1'b0;
  logic rst_bus = 1'b1;

  serial_bus_arbiter_if #(.AW(AW), .DW(DW), .SW(SW)) m0_if ();
  serial_bus_arbiter_if #(.AW(AW), .DW(DW), .SW(SW)) m1_if ();
  serial_bus_arbiter_if #(.AW(AW), .DW(DW), .SW(SW)) s_if ();

  serial_bus_arbiter #(
    .AW(AW), .DW(DW), .SW(SW), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_bus (clk_bus),
    .rst_bus (rst_bus),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if)
  );

  always #5 clk_bus = ~clk_bus;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    bit rst;
    bit m0_cyc;
    bit m0_stb;
    bit m1_cyc;
    bit m1_stb;
    bit s_ack;
    bit s_stall;
  } stim_t;

  // exp = {s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack, m0_err}
  typedef struct {
    stim_t      stim;
    logic [6:0] exp;
    string      name;
  } vector_t;

  // Behavioural model: is a master holding the bus, did the watchdog just fire,
  // who holds it, who went last, how many requests await an answer, and how long
  // the slave has been silent.
  int mdl_busy    = 0;
  int mdl_abort   = 0;
  int mdl_owner   = 0;
  int mdl_last    = 1;
  int mdl_pending = 0;
  int mdl_quiet   = 0;

  function automatic stim_t mk(bit rst, bit m0c, bit m0s, bit m1c, bit m1s, bit ack, bit stall);
    stim_t st;
    st.rst = rst; st.m0_cyc = m0c; st.m0_stb = m0s; st.m1_cyc = m1c; st.m1_stb = m1s;
    st.s_ack = ack; st.s_stall = stall;
    return st;
  endfunction

  function automatic vector_t vec(stim_t st, logic [6:0] e, string n);
    vector_t v;
    v.stim = st; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic applyStimulus(input stim_t st);
    rst_bus    = st.rst;
    m0_if.cyc  = st.m0_cyc;
    m0_if.stb  = st.m0_stb;
    m1_if.cyc  = st.m1_cyc;
    m1_if.stb  = st.m1_stb;
    s_if.ack   = st.s_ack;
    s_if.stall = st.s_stall;
    s_if.err   = 1'b0;
    s_if.rty   = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Advance the model by the edge the DUT is about to see, using the inputs now applied.
  task automatic modelStep();
    int  oc, os, prior, issued, answered, timed_out;
    if (rst_bus) begin
      mdl_busy = 0; mdl_abort = 0; mdl_owner = 0; mdl_last = 1; mdl_pending = 0; mdl_quiet = 0;
    end else if (mdl_abort == 1) begin
      mdl_abort = 0; mdl_busy = 0; mdl_last = mdl_owner; mdl_pending = 0; mdl_quiet = 0;
    end else if (mdl_busy == 0) begin
      mdl_pending = 0; mdl_quiet = 0;
      if (m0_if.cyc || m1_if.cyc) begin
        if (m0_if.cyc && m1_if.cyc) mdl_owner = 1 - mdl_last;
        else                        mdl_owner = m1_if.cyc ? 1 : 0;
        mdl_busy = 1;
      end
    end else begin
      oc = (mdl_owner == 1) ? int'(m1_if.cyc) : int'(m0_if.cyc);
      os = (mdl_owner == 1) ? int'(m1_if.stb) : int'(m0_if.stb);
      if (oc == 0) begin
        mdl_busy = 0; mdl_last = mdl_owner; mdl_pending = 0; mdl_quiet = 0;
      end else begin
        prior     = mdl_pending;
        answered  = (s_if.ack || s_if.err || s_if.rty) ? 1 : 0;
        issued    = (os == 1 && prior < MAX_OUT && !s_if.stall) ? 1 : 0;
        timed_out = (mdl_quiet == TIMEOUT - 1) ? 1 : 0;
        mdl_quiet   = (prior == 0 || answered == 1) ? 0 : mdl_quiet + 1;
        mdl_pending = prior + issued - ((answered == 1 && prior > 0) ? 1 : 0);
        if (timed_out == 1) begin
          mdl_busy = 0; mdl_abort = 1;
        end
      end
    end
  endtask

  // {s_cyc, s_stb, m0 ack/err/rty/stall, m1 ack/err/rty/stall}
  function automatic logic [9:0] expectCtrl();
    logic oc, os, scyc, sstb;
    logic [3:0] r0, r1, rsp;
    oc   = (mdl_owner == 1) ? m1_if.cyc : m0_if.cyc;
    os   = (mdl_owner == 1) ? m1_if.stb : m0_if.stb;
    scyc = (mdl_busy == 1) && oc;
    sstb = scyc && os && (mdl_pending < MAX_OUT);
    r0   = 4'b0001;
    r1   = 4'b0001;
    if (mdl_busy == 1) begin
      rsp = {s_if.ack, s_if.err, s_if.rty, s_if.stall || (mdl_pending == MAX_OUT)};
      if (mdl_owner == 1) r1 = rsp; else r0 = rsp;
    end else if (mdl_abort == 1) begin
      if (mdl_owner == 1) r1 = 4'b0101; else r0 = 4'b0101;
    end
    return {scyc, sstb, r0, r1};
  endfunction

  function automatic logic [DW-1:0] expectDat(int m);
    return (mdl_busy == 1 && mdl_owner == m) ? s_if.dat_r : '0;
  endfunction

  task automatic tick();
    modelStep();
    @(posedge clk_bus);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_bus);
  endtask

  task automatic runVector(input vector_t v);
    logic [6:0] act;
    string fld [7];
    fld = '{"m0_err", "m1_ack", "m0_ack", "m1_stall", "m0_stall", "s_stb", "s_cyc"};
    applyStimulus(v.stim);
    settle();
    act = {s_if.cyc, s_if.stb, m0_if.stall, m1_if.stall, m0_if.ack, m1_if.ack, m0_if.err};
    for (int b = 0; b < 7; b++) begin
      checkOutput({v.name, ".", fld[b]}, 32'(act[b]), 32'(v.exp[b]));
    end
    tick();
  endtask

  // Two reset edges, checking the idle outputs after the first one.
  task automatic doReset();
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0));
    tick();
    settle();
    checkOutput("reset.s_cyc",    32'(s_if.cyc),   32'd0);
    checkOutput("reset.s_stb",    32'(s_if.stb),   32'd0);
    checkOutput("reset.m0_stall", 32'(m0_if.stall), 32'd1);
    checkOutput("reset.m1_stall", 32'(m1_if.stall), 32'd1);
    checkOutput("reset.acks",     32'({m0_if.ack, m1_if.ack, m0_if.err, m1_if.err}), 32'd0);
    checkOutput("reset.m0_dat",   m0_if.dat_r, 32'd0);
    tick();
  endtask

  vector_t tieVec [10];

  initial begin
    stim_t      st;
    logic [9:0] expc, actc;
    int         ack_pct;

    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0));
    m0_if.we = 1'b1; m0_if.adr = 32'h1000_0000; m0_if.dat_w = 32'hA0A0_0000; m0_if.sel = 4'hF;
    m1_if.we = 1'b0; m1_if.adr = 32'h2000_0000; m1_if.dat_w = 32'hB0B0_0000; m1_if.sel = 4'h3;
    s_if.dat_r = 32'h5A5A_1234;

    tieVec[0] = vec(mk(0, 1, 0, 1, 0, 0, 0), 7'b0011000, "tie_c0_idle");
    tieVec[1] = vec(mk(0, 1, 0, 1, 0, 0, 0), 7'b1001000, "tie_c1_m0_owns");
    tieVec[2] = vec(mk(0, 1, 1, 1, 0, 0, 0), 7'b1101000, "tie_c2_stb");
    tieVec[3] = vec(mk(0, 1, 0, 1, 0, 1, 0), 7'b1001100, "tie_c3_ack");
    tieVec[4] = vec(mk(0, 1, 0, 1, 0, 0, 1), 7'b1011000, "tie_c4_slave_stall");
    tieVec[5] = vec(mk(0, 0, 0, 1, 0, 0, 0), 7'b0001000, "tie_c5_m0_release");
    tieVec[6] = vec(mk(0, 0, 0, 1, 0, 0, 0), 7'b0011000, "tie_c6_idle");
    tieVec[7] = vec(mk(0, 0, 0, 1, 0, 0, 0), 7'b1010000, "tie_c7_m1_owns");
    tieVec[8] = vec(mk(0, 0, 0, 1, 1, 1, 0), 7'b1110010, "tie_c8_m1_ack");
    tieVec[9] = vec(mk(0, 0, 0, 0, 0, 0, 0), 7'b0010000, "tie_c9_m1_release");

    $display("[TB] reset and round-robin tie");
    doReset();
    for (int i = 0; i < 10; i++) runVector(tieVec[i]);

    $display("[TB] pipeline cap and outstanding accounting");
    doReset();
    runVector(vec(mk(0, 1, 0, 0, 0, 0, 0), 7'b0011000, "cap_p0_idle"));
    runVector(vec(mk(0, 1, 1, 0, 0, 0, 0), 7'b1101000, "cap_p1_acc1"));
    runVector(vec(mk(0, 1, 1, 0, 0, 0, 0), 7'b1101000, "cap_p2_acc2"));
    runVector(vec(mk(0, 1, 1, 0, 0, 0, 0), 7'b1101000, "cap_p3_acc3"));
    runVector(vec(mk(0, 1, 1, 0, 0, 0, 0), 7'b1101000, "cap_p4_acc4"));
    runVector(vec(mk(0, 1, 1, 0, 0, 0, 0), 7'b1011000, "cap_p5_full"));
    runVector(vec(mk(0, 1, 1, 0, 0, 1, 0), 7'b1011100, "cap_p6_ack_full"));
    runVector(vec(mk(0, 1, 1, 0, 0, 1, 0), 7'b1101100, "cap_p7_ack_and_accept"));
    runVector(vec(mk(0, 1, 0, 0, 0, 1, 0), 7'b1001100, "cap_p8_ack"));
    runVector(vec(mk(0, 1, 1, 0, 0, 0, 0), 7'b1101000, "cap_p9_refill3"));
    runVector(vec(mk(0, 1, 1, 0, 0, 0, 0), 7'b1101000, "cap_p10_refill4"));
    runVector(vec(mk(0, 1, 1, 0, 0, 0, 0), 7'b1011000, "cap_p11_full_again"));
    runVector(vec(mk(0, 0, 0, 0, 0, 0, 0), 7'b0011000, "cap_p12_release"));
    runVector(vec(mk(0, 0, 0, 0, 0, 1, 0), 7'b0011000, "cap_p13_late_ack"));

    $display("[TB] watchdog abort");
    doReset();
    runVector(vec(mk(0, 1, 0, 0, 0, 0, 0), 7'b0011000, "wd_c0_idle"));
    runVector(vec(mk(0, 1, 1, 0, 0, 0, 0), 7'b1101000, "wd_c1_accept"));
    for (int k = 2; k <= 9; k++) begin
      runVector(vec(mk(0, 1, 0, 0, 0, 0, 0), 7'b1001000, $sformatf("wd_c%0d_wait", k)));
    end
    runVector(vec(mk(0, 1, 0, 0, 0, 0, 0), 7'b0011001, "wd_c10_abort"));
    runVector(vec(mk(0, 1, 0, 0, 0, 0, 0), 7'b0011000, "wd_c11_idle"));
    runVector(vec(mk(0, 1, 0, 0, 0, 0, 0), 7'b1001000, "wd_c12_regrant"));
    runVector(vec(mk(0, 0, 0, 0, 0, 0, 0), 7'b0001000, "wd_c13_release"));

    $display("[TB] abandon with outstanding requests");
    doReset();
    runVector(vec(mk(0, 0, 0, 1, 0, 0, 0), 7'b0011000, "ab_c0_idle"));
    runVector(vec(mk(0, 0, 0, 1, 1, 0, 0), 7'b1110000, "ab_c1_acc1"));
    runVector(vec(mk(0, 1, 0, 1, 1, 0, 0), 7'b1110000, "ab_c2_acc2"));
    runVector(vec(mk(0, 1, 0, 0, 0, 0, 0), 7'b0010000, "ab_c3_m1_drops"));
    runVector(vec(mk(0, 1, 0, 0, 0, 1, 0), 7'b0011000, "ab_c4_late_ack"));
    runVector(vec(mk(0, 1, 0, 0, 0, 0, 0), 7'b1001000, "ab_c5_m0_owns"));
    runVector(vec(mk(0, 0, 0, 0, 0, 0, 0), 7'b0001000, "ab_c6_release"));

    $display("[TB] reset in the middle of a bus cycle");
    doReset();
    runVector(vec(mk(0, 1, 0, 0, 0, 0, 0), 7'b0011000, "mr_c0_idle"));
    runVector(vec(mk(0, 1, 1, 0, 0, 0, 0), 7'b1101000, "mr_c1_accept"));
    runVector(vec(mk(1, 1, 0, 0, 0, 0, 0), 7'b1001000, "mr_c2_reset_edge"));
    runVector(vec(mk(0, 1, 0, 0, 0, 0, 0), 7'b0011000, "mr_c3_idle"));
    runVector(vec(mk(0, 1, 0, 0, 0, 0, 0), 7'b1001000, "mr_c4_regrant"));

    $display("[TB] randomized traffic against the model");
    doReset();
    ack_pct = 30;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) ack_pct = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 25 : 60);
      st.rst     = ($urandom_range(0, 399) == 0);
      st.m0_cyc  = m0_if.cyc ? ($urandom_range(0, 11) != 0) : ($urandom_range(0, 3) == 0);
      st.m1_cyc  = m1_if.cyc ? ($urandom_range(0, 11) != 0) : ($urandom_range(0, 3) == 0);
      st.m0_stb  = st.m0_cyc && ($urandom_range(0, 1) == 1);
      st.m1_stb  = st.m1_cyc && ($urandom_range(0, 1) == 1);
      st.s_ack   = ($urandom_range(0, 99) < ack_pct);
      st.s_stall = ($urandom_range(0, 3) == 0);
      applyStimulus(st);
      s_if.err    = ($urandom_range(0, 49) == 0);
      s_if.rty    = ($urandom_range(0, 49) == 0);
      s_if.dat_r  = $urandom;
      m0_if.adr   = $urandom;
      m0_if.dat_w = $urandom;
      m0_if.sel   = 4'($urandom);
      m0_if.we    = 1'($urandom);
      m1_if.adr   = $urandom;
      m1_if.dat_w = $urandom;
      m1_if.sel   = 4'($urandom);
      m1_if.we    = 1'($urandom);
      settle();
      expc = expectCtrl();
      actc = {s_if.cyc, s_if.stb, m0_if.ack, m0_if.err, m0_if.rty, m0_if.stall,
              m1_if.ack, m1_if.err, m1_if.rty, m1_if.stall};
      checkOutput($sformatf("rand%0d.ctrl", n), 32'(actc), 32'(expc));
      checkOutput($sformatf("rand%0d.m0_dat", n), m0_if.dat_r, expectDat(0));
      checkOutput($sformatf("rand%0d.m1_dat", n), m1_if.dat_r, expectDat(1));
      if (expc[9]) begin
        checkOutput($sformatf("rand%0d.s_adr", n), s_if.adr,
                    (mdl_owner == 1) ? m1_if.adr : m0_if.adr);
        checkOutput($sformatf("rand%0d.s_dat", n), s_if.dat_w,
                    (mdl_owner == 1) ? m1_if.dat_w : m0_if.dat_w);
        checkOutput($sformatf("rand%0d.s_we_sel", n), 32'({s_if.we, s_if.sel}),
                    (mdl_owner == 1) ? 32'({m1_if.we, m1_if.sel}) : 32'({m0_if.we, m0_if.sel}));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
